// File: rtl/pll_lock_sequencer.sv
// Fabric PLL power-up/recovery sequencer: drives PLL reset, qualifies lock,
// and releases downstream domain resets in staged order.
//
//  state         | meaning
//  RESET     (0) | pll_reset held high for RST_CYCLES, all domains in reset
//  WAIT_LOCK (1) | PLL running, waiting up to LOCK_TIMEOUT for synced lock
//  STABLE    (2) | lock seen, must stay high LOCK_STABLE consecutive cycles
//  RELEASE   (3) | dom_rst bits released low-to-high, STAGE_GAP apart
//  RUN       (4) | all domains released, ready=1
//  FAULT     (5) | retries exhausted, held until restart or reset
module pll_lock_sequencer #(
  parameter int RST_CYCLES   = 64,
  parameter int LOCK_TIMEOUT = 500000,
  parameter int LOCK_STABLE  = 1024,
  parameter int STAGE_GAP    = 256,
  parameter int NUM_STAGES   = 2,
  parameter int MAX_RETRY    = 3,
  parameter int CNT_W        = 20
) (
  input  logic                  clkin,
  input  logic                  reset,
  input  logic                  restart,
  input  logic                  pll_lock,
  output logic                  pll_reset,
  output logic [NUM_STAGES-1:0] dom_rst,
  output logic                  ready,
  output logic                  fault,
  output logic [2:0]            retry_cnt,
  output logic [7:0]            lost_cnt,
  output logic [2:0]            state
);

  typedef enum logic [2:0] {
    S_RESET     = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RELEASE   = 3'd3,
    S_RUN       = 3'd4,
    S_FAULT     = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0]      RST_LAST     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]      TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]      STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0]      GAP_LAST     = CNT_W'(STAGE_GAP - 1);
  localparam logic [2:0]            RETRY_MAX    = 3'(MAX_RETRY);
  localparam logic [NUM_STAGES-1:0] ALL_RST      = '1;

  state_t                  st;
  logic [CNT_W-1:0]        timer;
  logic                    lock_meta;
  logic                    lock_s;
  logic [NUM_STAGES-1:0]   dom_shift;

  // Shifting left releases bit 0 first, then bit 1, ... so order is structural.
  assign dom_shift = dom_rst << 1;
  assign state     = st;

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      st        <= S_RESET;
      timer     <= '0;
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
      pll_reset <= 1'b1;
      dom_rst   <= ALL_RST;
      ready     <= 1'b0;
      fault     <= 1'b0;
      retry_cnt <= '0;
      lost_cnt  <= '0;
    end else begin
      lock_meta <= pll_lock;
      lock_s    <= lock_meta;
      if (restart) begin
        st        <= S_RESET;
        timer     <= '0;
        retry_cnt <= '0;
        fault     <= 1'b0;
        pll_reset <= 1'b1;
        dom_rst   <= ALL_RST;
        ready     <= 1'b0;
      end else if ((st == S_RELEASE || st == S_RUN) && !lock_s) begin
        st        <= S_RESET;
        timer     <= '0;
        retry_cnt <= '0;
        pll_reset <= 1'b1;
        dom_rst   <= ALL_RST;
        ready     <= 1'b0;
        if (lost_cnt != 8'hFF) lost_cnt <= lost_cnt + 8'd1;
      end else begin
        case (st)
          S_RESET: begin
            if (timer == RST_LAST) begin
              st        <= S_WAIT_LOCK;
              timer     <= '0;
              pll_reset <= 1'b0;
            end else begin
              timer <= timer + 1'b1;
            end
          end
          S_WAIT_LOCK: begin
            // Timeout outranks a lock rise arriving on the same cycle.
            if (timer == TIMEOUT_LAST) begin
              timer     <= '0;
              pll_reset <= 1'b1;
              if (retry_cnt == RETRY_MAX) begin
                st    <= S_FAULT;
                fault <= 1'b1;
              end else begin
                st        <= S_RESET;
                retry_cnt <= retry_cnt + 3'd1;
              end
            end else if (lock_s) begin
              st    <= S_STABLE;
              timer <= '0;
            end else begin
              timer <= timer + 1'b1;
            end
          end
          S_STABLE: begin
            if (!lock_s) begin
              st    <= S_WAIT_LOCK;
              timer <= '0;
            end else if (timer == STABLE_LAST) begin
              st      <= S_RELEASE;
              timer   <= '0;
              dom_rst <= dom_shift;
              ready   <= (dom_shift == '0);
            end else begin
              timer <= timer + 1'b1;
            end
          end
          S_RELEASE: begin
            if (dom_rst == '0) begin
              st <= S_RUN;
            end else if (timer == GAP_LAST) begin
              timer   <= '0;
              dom_rst <= dom_shift;
              if (dom_shift == '0) begin
                ready <= 1'b1;
                st    <= S_RUN;
              end
            end else begin
              timer <= timer + 1'b1;
            end
          end
          S_RUN: begin
          end
          S_FAULT: begin
            pll_reset <= 1'b1;
            dom_rst   <= ALL_RST;
            fault     <= 1'b1;
            ready     <= 1'b0;
          end
          default: begin
            st        <= S_RESET;
            timer     <= '0;
            pll_reset <= 1'b1;
            dom_rst   <= ALL_RST;
            ready     <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
